rom_loader_16: RTL

- Writer-side counterpart of the 16-bit program ROM.
- Receives a byte stream and assembles it into 16-bit words.
- Writes those words sequentially into the dual-use RAM that stands in for the 136020 program ROM image.
- Holds the CPU off until a full image with a matching checksum has been written.

---
 rtl/rom_loader_16.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rom_loader_16.sv
// Byte-stream loader for the 16-bit program ROM image RAM: assembles byte pairs
// into words, writes them sequentially, then verifies a 2-byte checksum trailer.
module rom_loader_16 #(
    parameter int ADDR_W     = 13,
    parameter int WORDS      = 8192,
    parameter int HIGH_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       checksum,
    output logic              cpu_hold
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BYTE0 = 3'd1;
    localparam logic [2:0] S_BYTE1 = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CK0   = 3'd4;
    localparam logic [2:0] S_CK1   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    logic [2:0]        state_q,    state_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q,    wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic [15:0]       wr_data_q,  wr_data_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              error_q,    error_d;
    logic [15:0]       checksum_q, checksum_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic [7:0]        ck_byte_q,  ck_byte_d;

    logic              xfer;
    logic [15:0]       ck_expected;

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        checksum_d  = checksum_q;
        cpu_hold_d  = cpu_hold_q;
        ck_byte_d   = ck_byte_q;
        xfer        = in_valid && in_ready_q;
        ck_expected = (HIGH_FIRST != 0) ? {ck_byte_q, in_data} : {in_data, ck_byte_q};

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_BYTE0;
                    wr_addr_d  = '0;
                    checksum_d = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    busy_d     = 1'b1;
                    cpu_hold_d = 1'b1;
                end
            end
            S_BYTE0: begin
                if (xfer) begin
                    if (HIGH_FIRST != 0) wr_data_d[15:8] = in_data;
                    else                 wr_data_d[7:0]  = in_data;
                    state_d = S_BYTE1;
                end
            end
            S_BYTE1: begin
                if (xfer) begin
                    if (HIGH_FIRST != 0) wr_data_d[7:0]  = in_data;
                    else                 wr_data_d[15:8] = in_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                checksum_d = checksum_q + wr_data_q;
                // Address parks on the last word so it never wraps past WORDS-1.
                if (wr_addr_q == LAST_ADDR) begin
                    state_d = S_CK0;
                end else begin
                    wr_addr_d = wr_addr_q + 1'b1;
                    state_d   = S_BYTE0;
                end
            end
            S_CK0: begin
                if (xfer) begin
                    ck_byte_d = in_data;
                    state_d   = S_CK1;
                end
            end
            S_CK1: begin
                if (xfer) begin
                    busy_d = 1'b0;
                    if (ck_expected == checksum_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d    = S_ERR;
                        error_d    = 1'b1;
                        cpu_hold_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered handshake outputs are decoded from the next state.
        in_ready_d = (state_d == S_BYTE0) || (state_d == S_BYTE1) ||
                     (state_d == S_CK0)   || (state_d == S_CK1);
        wr_en_d    = (state_d == S_WRITE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            checksum_q <= '0;
            cpu_hold_q <= 1'b1;
            ck_byte_q  <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            checksum_q <= checksum_d;
            cpu_hold_q <= cpu_hold_d;
            ck_byte_q  <= ck_byte_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign checksum = checksum_q;
    assign cpu_hold = cpu_hold_q;

endmodule
